// File: rtl/soc_sim_ctrl.sv
// Bring-up controller for the RISC-V SoC: sequences the SoC reset, counts run cycles,
// and snoops the data-write bus for tohost (pass/fail) and console writes.
module soc_sim_ctrl #(
    parameter int unsigned          ADDR_W       = 32,
    parameter int unsigned          DATA_W       = 32,
    parameter int unsigned          CNT_W        = 32,
    parameter int unsigned          RESET_CYCLES = 8,
    parameter int unsigned          TIMEOUT      = 1000000,
    parameter logic [ADDR_W-1:0]    TOHOST_ADDR  = 32'h4000_0000,
    parameter logic [ADDR_W-1:0]    CONSOLE_ADDR = 32'h4000_0004,
    parameter bit                   HALT_ON_DONE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              soc_reset,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [DATA_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              char_valid,
    output logic [7:0]        char_data
);
    typedef enum logic [2:0] {S_HOLD, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    localparam int unsigned      HW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [HW-1:0]     hold_cnt;
    logic              tohost_wr, console_wr;
    logic              soc_reset_d, running_d, done_d, pass_d, timed_out_d;

    assign tohost_wr  = wr_valid && (wr_addr == TOHOST_ADDR);
    assign console_wr = wr_valid && (wr_addr == CONSOLE_ADDR);

    always_ff @(posedge clk) begin
        if (reset) state <= S_HOLD;
        else       state <= state_nxt;
    end

    // A terminating tohost write outranks the watchdog expiring in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            S_RUN: begin
                if (tohost_wr && wr_data == DATA_W'(1))            state_nxt = S_PASS;
                else if (tohost_wr && wr_data[0])                  state_nxt = S_FAIL;
                else if (TIMEOUT != 0 && cycle_count == TO_LAST)   state_nxt = S_TIMEOUT;
            end
            default: state_nxt = state;
        endcase
    end

    // Status is decoded from the next state so the registered outputs track the transition edge.
    always_comb begin
        running_d   = (state_nxt == S_RUN);
        pass_d      = (state_nxt == S_PASS);
        timed_out_d = (state_nxt == S_TIMEOUT);
        done_d      = (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TIMEOUT);
        soc_reset_d = (state_nxt == S_HOLD) || (done_d && HALT_ON_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt    <= '0;
            soc_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timed_out   <= 1'b0;
            exit_code   <= '0;
            cycle_count <= '0;
            char_valid  <= 1'b0;
            char_data   <= '0;
        end else begin
            soc_reset  <= soc_reset_d;
            running    <= running_d;
            done       <= done_d;
            pass       <= pass_d;
            timed_out  <= timed_out_d;
            char_valid <= 1'b0;
            if (state == S_HOLD && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 1'b1;
            if (state == S_RUN) begin
                if (cycle_count != '1)
                    cycle_count <= cycle_count + 1'b1;
                if (state_nxt == S_FAIL)
                    exit_code <= wr_data >> 1;
                if (console_wr && state_nxt == S_RUN) begin
                    char_valid <= 1'b1;
                    char_data  <= wr_data[7:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_soc_sim_ctrl.sv
// Directed bench for soc_sim_ctrl: three instances cover default timing, a short
// watchdog, and a disabled watchdog with a narrow saturating counter and no halt.
module tb_soc_sim_ctrl;
    localparam logic [31:0] TH  = 32'h4000_0000;
    localparam logic [31:0] CON = 32'h4000_0004;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        wv  [3];
    logic [31:0] wa  [3];
    logic [31:0] wd  [3];
    logic        sr  [3];
    logic        run [3];
    logic        dn  [3];
    logic        ps  [3];
    logic        to  [3];
    logic        cv  [3];
    logic [31:0] ec  [3];
    logic [31:0] cc0, cc1;
    logic [7:0]  cc2;
    logic [7:0]  cd  [3];

    int tests = 0;
    int fails = 0;

    soc_sim_ctrl u_dut0 (
        .clk(clk), .reset(rst[0]), .wr_valid(wv[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
        .soc_reset(sr[0]), .running(run[0]), .done(dn[0]), .pass(ps[0]), .timed_out(to[0]),
        .exit_code(ec[0]), .cycle_count(cc0), .char_valid(cv[0]), .char_data(cd[0]));

    soc_sim_ctrl #(.TIMEOUT(50)) u_dut1 (
        .clk(clk), .reset(rst[1]), .wr_valid(wv[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
        .soc_reset(sr[1]), .running(run[1]), .done(dn[1]), .pass(ps[1]), .timed_out(to[1]),
        .exit_code(ec[1]), .cycle_count(cc1), .char_valid(cv[1]), .char_data(cd[1]));

    soc_sim_ctrl #(.CNT_W(8), .RESET_CYCLES(1), .TIMEOUT(0), .HALT_ON_DONE(1'b0)) u_dut2 (
        .clk(clk), .reset(rst[2]), .wr_valid(wv[2]), .wr_addr(wa[2]), .wr_data(wd[2]),
        .soc_reset(sr[2]), .running(run[2]), .done(dn[2]), .pass(ps[2]), .timed_out(to[2]),
        .exit_code(ec[2]), .cycle_count(cc2), .char_valid(cv[2]), .char_data(cd[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d);
        wv[i] = 1'b1; wa[i] = a; wd[i] = d;
        step(1);
        wv[i] = 1'b0;
    endtask

    task automatic chk_rst(input int i, input logic [31:0] cc);
        chk("rst_soc_reset", sr[i], 1);
        chk("rst_running", run[i], 0);
        chk("rst_done", dn[i], 0);
        chk("rst_pass", ps[i], 0);
        chk("rst_timed_out", to[i], 0);
        chk("rst_char_valid", cv[i], 0);
        chk("rst_exit_code", ec[i], 0);
        chk("rst_cycle_count", cc, 0);
        chk("rst_char_data", cd[i], 0);
    endtask

    // Pulse reset for n cycles, release, and wait out the 8-cycle hold of dut0/dut1.
    task automatic restart(input int i, input int n);
        rst[i] = 1'b1;
        step(n);
        rst[i] = 1'b0;
        step(8);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; wv[i] = 1'b0; wa[i] = '0; wd[i] = '0;
        end

        // dut0: reset sequencing, console writes ignored while holding
        step(3);
        chk_rst(0, cc0);
        rst[0] = 1'b0;
        wv[0] = 1'b1; wa[0] = CON; wd[0] = 32'h41;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk("hold_soc_reset", sr[0], 1);
            chk("hold_running", run[0], 0);
            chk("hold_char_valid", cv[0], 0);
        end
        wv[0] = 1'b0;
        step(1);
        chk("run_soc_reset", sr[0], 0);
        chk("run_running", run[0], 1);
        chk("run_cc0", cc0, 0);
        chk("run_cv0", cv[0], 0);

        // back-to-back console writes
        wv[0] = 1'b1; wa[0] = CON; wd[0] = 32'h48;
        step(1);
        chk("con1_valid", cv[0], 1);
        chk("con1_data", cd[0], 8'h48);
        chk("con1_cc", cc0, 1);
        wd[0] = 32'h69;
        step(1);
        chk("con2_valid", cv[0], 1);
        chk("con2_data", cd[0], 8'h69);
        wv[0] = 1'b0;
        step(1);
        chk("con3_valid", cv[0], 0);
        chk("con3_data_hold", cd[0], 8'h69);
        chk("con3_cc", cc0, 3);

        // even tohost value is not a verdict
        wr(0, TH, 32'h4);
        chk("even_running", run[0], 1);
        chk("even_done", dn[0], 0);
        chk("even_cc", cc0, 4);

        // PASS at run cycle 100
        step(96);
        chk("pre_pass_cc", cc0, 100);
        wr(0, TH, 32'h1);
        chk("pass_done", dn[0], 1);
        chk("pass_pass", ps[0], 1);
        chk("pass_running", run[0], 0);
        chk("pass_timed_out", to[0], 0);
        chk("pass_exit", ec[0], 0);
        chk("pass_cc", cc0, 101);
        chk("pass_soc_reset", sr[0], 1);

        // writes in PASS are ignored
        wr(0, CON, 32'h48);
        chk("pass_con_valid", cv[0], 0);
        wr(0, CON, 32'h69);
        chk("pass_con_valid2", cv[0], 0);
        chk("pass_con_data", cd[0], 8'h69);
        wr(0, TH, 32'h7);
        chk("pass_sticky", ps[0], 1);
        chk("pass_exit_held", ec[0], 0);
        chk("pass_cc_frozen", cc0, 101);

        // reset from PASS, fresh run, then FAIL
        rst[0] = 1'b1;
        step(1);
        chk_rst(0, cc0);
        rst[0] = 1'b0;
        step(8);
        chk("rerun_running", run[0], 1);
        chk("rerun_soc_reset", sr[0], 0);
        chk("rerun_cc", cc0, 0);
        step(5);
        wr(0, TH, 32'h4);
        chk("fail_pre_running", run[0], 1);
        chk("fail_pre_cc", cc0, 6);
        wr(0, TH, 32'h7);
        chk("fail_done", dn[0], 1);
        chk("fail_pass", ps[0], 0);
        chk("fail_exit", ec[0], 3);
        chk("fail_cc", cc0, 7);
        chk("fail_soc_reset", sr[0], 1);
        step(3);
        chk("fail_cc_frozen", cc0, 7);
        chk("fail_exit_held", ec[0], 3);

        // reset from FAIL and then mid-run
        rst[0] = 1'b1;
        step(1);
        chk_rst(0, cc0);
        rst[0] = 1'b0;
        step(8);
        chk("rerun2_running", run[0], 1);
        step(10);
        chk("midrun_cc", cc0, 10);
        restart(0, 1);
        chk("rerun3_running", run[0], 1);
        chk("rerun3_cc", cc0, 0);
        chk("rerun3_exit", ec[0], 0);

        // dut1: watchdog with TIMEOUT=50
        rst[0] = 1'b1;
        restart(1, 2);
        chk("to_running", run[1], 1);
        step(49);
        chk("to_pre_cc", cc1, 49);
        chk("to_pre_running", run[1], 1);
        step(1);
        chk("to_timed_out", to[1], 1);
        chk("to_done", dn[1], 1);
        chk("to_pass", ps[1], 0);
        chk("to_running_off", run[1], 0);
        chk("to_cc", cc1, 50);
        chk("to_soc_reset", sr[1], 1);
        chk("to_exit", ec[1], 0);
        step(5);
        chk("to_cc_frozen", cc1, 50);
        restart(1, 1);
        step(49);
        wr(1, TH, 32'h1);
        chk("to_race_pass", ps[1], 1);
        chk("to_race_timed_out", to[1], 0);
        chk("to_race_cc", cc1, 50);

        // dut2: watchdog off, 8-bit counter saturates, one-cycle hold, SoC left running
        rst[1] = 1'b1;
        rst[2] = 1'b1;
        step(2);
        rst[2] = 1'b0;
        step(1);
        chk("nto_soc_reset", sr[2], 0);
        chk("nto_running", run[2], 1);
        chk("nto_cc0", cc2, 0);
        step(9999);
        chk("nto_running_late", run[2], 1);
        chk("nto_done_late", dn[2], 0);
        chk("nto_cc_sat", cc2, 8'hff);
        wr(2, TH, 32'h1);
        chk("nto_pass", ps[2], 1);
        chk("nto_soc_reset_nohalt", sr[2], 0);
        chk("nto_cc_sat_frozen", cc2, 8'hff);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
